// File: rtl/dcnn_stream_loader_if.sv
// Handshake and buffer-write bundle between the host stream, the loader and the CNN RAMs.
interface dcnn_stream_loader_if #(
    parameter int BUS_W  = 16,
    parameter int PACK   = 1,
    parameter int ADDR_W = 10
);
    localparam int DATA_W = BUS_W * PACK;

    logic              load;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic [BUS_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;

    modport master (
        output load, base_addr, count, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
    );

    modport slave (
        input  load, base_addr, count, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
    );
endinterface

// File: rtl/dcnn_stream_loader.sv
// Streams a burst of bus beats into a DCNN buffer, packing PACK beats per word
// and writing consecutive addresses from the latched base.
module dcnn_stream_loader #(
    parameter int BUS_W  = 16,
    parameter int PACK   = 1,
    parameter int ADDR_W = 10
) (
    input logic                  clk,
    input logic                  rst,
    dcnn_stream_loader_if.slave  bus
);
    localparam int DATA_W = BUS_W * PACK;
    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(PACK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [IDX_W-1:0]  beat_idx_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W:0]   words_written_q;

    logic [ADDR_W-1:0] base_p0;
    logic [ADDR_W:0]   count_p0;
    logic [DATA_W-1:0] pack_p0;

    logic              accept;
    logic              last_word;
    logic [ADDR_W:0]   ww_inc;
    logic [DATA_W-1:0] word_nxt;

    function automatic logic [DATA_W-1:0] insert_lane(
        input logic [DATA_W-1:0] word,
        input logic [BUS_W-1:0]  beat,
        input logic [IDX_W-1:0]  idx
    );
        logic [DATA_W-1:0] w;
        w = word;
        for (int k = 0; k < PACK; k++) begin
            if (idx == IDX_W'(k)) w[k*BUS_W +: BUS_W] = beat;
        end
        return w;
    endfunction

    assign accept    = in_ready_q & bus.in_valid;
    assign ww_inc    = words_written_q + (ADDR_W+1)'(1);
    assign last_word = (ww_inc == count_p0);
    assign word_nxt  = insert_lane(pack_p0, bus.in_data, beat_idx_q);

    // Stage p0: burst parameters and the partially assembled word (no reset needed)
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.load) begin
            base_p0  <= bus.base_addr;
            count_p0 <= bus.count;
        end
        if (accept) pack_p0 <= word_nxt;
    end

    // Stage p1: control FSM and registered buffer-write outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            beat_idx_q      <= '0;
            in_ready_q      <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        busy_q          <= 1'b1;
                        words_written_q <= '0;
                        beat_idx_q      <= '0;
                        if (bus.count != '0) begin
                            state_q    <= ST_RECV;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        if (beat_idx_q == LAST_BEAT) begin
                            mem_we_q        <= 1'b1;
                            mem_wdata_q     <= word_nxt;
                            mem_addr_q      <= base_p0 + words_written_q[ADDR_W-1:0];
                            words_written_q <= ww_inc;
                            beat_idx_q      <= '0;
                            if (last_word) begin
                                // Drop ready together with the final write so no extra beat is taken
                                state_q    <= ST_DONE;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end else begin
                            beat_idx_q <= beat_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.words_written = words_written_q;
endmodule

// File: tb/tb_dcnn_stream_loader.sv
// Directed bench for dcnn_stream_loader: a PACK=1 instance driven from a cycle table,
// and a PACK=2 instance driven by hand-written gap and reset sequences.
module tb_dcnn_stream_loader;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   we2_cnt;

    dcnn_stream_loader_if #(.BUS_W(16), .PACK(1), .ADDR_W(10)) b1 ();
    dcnn_stream_loader_if #(.BUS_W(16), .PACK(2), .ADDR_W(10)) b2 ();

    dcnn_stream_loader #(.BUS_W(16), .PACK(1), .ADDR_W(10)) u_p1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    dcnn_stream_loader #(.BUS_W(16), .PACK(2), .ADDR_W(10)) u_p2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [9:0]  base;
        logic [10:0] cnt;
        logic        vld;
        logic [15:0] data;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic        busy;
        logic        done;
        logic [10:0] ww;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic l, input logic [9:0] b, input logic [10:0] c, input logic v,
        input logic [15:0] d, input logic r, input logic w, input logic [9:0] a,
        input logic [15:0] wd, input logic bs, input logic dn, input logic [10:0] ww
    );
        vec_t t;
        t.load = l;  t.base = b;  t.cnt = c;   t.vld = v;   t.data = d;
        t.rdy  = r;  t.we   = w;  t.addr = a;  t.wd  = wd;  t.busy = bs;
        t.done = dn; t.ww   = ww;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we2_cnt += int'(b2.mem_we);
    endtask

    task automatic p2_drive(input logic l, input logic [9:0] b, input logic [10:0] c,
                            input logic v, input logic [15:0] d);
        b2.load = l; b2.base_addr = b; b2.count = c; b2.in_valid = v; b2.in_data = d;
    endtask

    task automatic chk_p2_zero(input string tag);
        chk({tag, ".in_ready"}, 32'(b2.in_ready), 32'd0);
        chk({tag, ".mem_we"}, 32'(b2.mem_we), 32'd0);
        chk({tag, ".mem_addr"}, 32'(b2.mem_addr), 32'd0);
        chk({tag, ".mem_wdata"}, b2.mem_wdata, 32'd0);
        chk({tag, ".busy"}, 32'(b2.busy), 32'd0);
        chk({tag, ".done"}, 32'(b2.done), 32'd0);
        chk({tag, ".ww"}, 32'(b2.words_written), 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        we2_cnt = 0;
        rst     = 1'b1;
        b1.load = 1'b0; b1.base_addr = '0; b1.count = '0; b1.in_valid = 1'b0; b1.in_data = '0;
        p2_drive(1'b0, 10'd0, 11'd0, 1'b0, 16'h0);

        // PACK=1 burst base 5
        vq.push_back(mk(1, 5, 3, 0, 16'h0,  1, 0, 0, 16'h0,  1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 16'hA1, 1, 1, 5, 16'hA1, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 1, 16'hA2, 1, 1, 6, 16'hA2, 1, 0, 2));
        vq.push_back(mk(0, 0, 0, 1, 16'hA3, 0, 1, 7, 16'hA3, 1, 1, 3));
        vq.push_back(mk(0, 0, 0, 1, 16'hEE, 0, 0, 0, 16'h0,  0, 0, 3));
        vq.push_back(mk(0, 0, 0, 0, 16'h0,  0, 0, 0, 16'h0,  0, 0, 3));
        // count = 0
        vq.push_back(mk(1, 9, 0, 0, 16'h0,  0, 0, 0, 16'h0,  1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 16'h0,  0, 0, 0, 16'h0,  0, 0, 0));
        // address wrap
        vq.push_back(mk(1, 1022, 4, 0, 16'h0,  1, 0, 0,    16'h0,  1, 0, 0));
        vq.push_back(mk(0, 0,    0, 1, 16'h10, 1, 1, 1022, 16'h10, 1, 0, 1));
        vq.push_back(mk(0, 0,    0, 1, 16'h11, 1, 1, 1023, 16'h11, 1, 0, 2));
        vq.push_back(mk(0, 0,    0, 1, 16'h12, 1, 1, 0,    16'h12, 1, 0, 3));
        vq.push_back(mk(0, 0,    0, 1, 16'h13, 0, 1, 1,    16'h13, 1, 1, 4));
        vq.push_back(mk(0, 0,    0, 0, 16'h0,  0, 0, 0,    16'h0,  0, 0, 4));
        // load while busy and during done is ignored; load in first idle cycle is taken
        vq.push_back(mk(1, 8,   3, 0, 16'h0,  1, 0, 0,  16'h0,  1, 0, 0));
        vq.push_back(mk(1, 100, 5, 1, 16'h21, 1, 1, 8,  16'h21, 1, 0, 1));
        vq.push_back(mk(1, 100, 5, 1, 16'h22, 1, 1, 9,  16'h22, 1, 0, 2));
        vq.push_back(mk(0, 0,   0, 1, 16'h23, 0, 1, 10, 16'h23, 1, 1, 3));
        vq.push_back(mk(1, 200, 2, 0, 16'h0,  0, 0, 0,  16'h0,  0, 0, 3));
        vq.push_back(mk(1, 50,  1, 0, 16'h0,  1, 0, 0,  16'h0,  1, 0, 0));
        vq.push_back(mk(0, 0,   0, 1, 16'h31, 0, 1, 50, 16'h31, 1, 1, 1));
        vq.push_back(mk(0, 0,   0, 0, 16'h0,  0, 0, 0,  16'h0,  0, 0, 1));

        step();
        step();
        chk_p2_zero("reset");
        chk("reset.p1_ready", 32'(b1.in_ready), 32'd0);
        chk("reset.p1_busy", 32'(b1.busy), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            b1.load = vq[i].load; b1.base_addr = vq[i].base; b1.count = vq[i].cnt;
            b1.in_valid = vq[i].vld; b1.in_data = vq[i].data;
            step();
            chk($sformatf("row%0d.in_ready", i), 32'(b1.in_ready), 32'(vq[i].rdy));
            chk($sformatf("row%0d.mem_we", i), 32'(b1.mem_we), 32'(vq[i].we));
            chk($sformatf("row%0d.busy", i), 32'(b1.busy), 32'(vq[i].busy));
            chk($sformatf("row%0d.done", i), 32'(b1.done), 32'(vq[i].done));
            chk($sformatf("row%0d.ww", i), 32'(b1.words_written), 32'(vq[i].ww));
            if (vq[i].we) begin
                chk($sformatf("row%0d.mem_addr", i), 32'(b1.mem_addr), 32'(vq[i].addr));
                chk($sformatf("row%0d.mem_wdata", i), 32'(b1.mem_wdata), 32'(vq[i].wd));
            end
        end
        b1.load = 1'b0; b1.in_valid = 1'b0;

        // PACK=2 with one-cycle valid gaps
        we2_cnt = 0;
        p2_drive(1, 10'd0, 11'd2, 0, 16'h0);    step();
        chk("gap.ready", 32'(b2.in_ready), 32'd1);
        p2_drive(0, 10'd0, 11'd0, 1, 16'h1111); step();
        chk("gap.we_b0", 32'(b2.mem_we), 32'd0);
        p2_drive(0, 10'd0, 11'd0, 0, 16'hDEAD); step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'h2222); step();
        chk("gap.w0_we", 32'(b2.mem_we), 32'd1);
        chk("gap.w0_addr", 32'(b2.mem_addr), 32'd0);
        chk("gap.w0_data", b2.mem_wdata, 32'h22221111);
        chk("gap.w0_ww", 32'(b2.words_written), 32'd1);
        p2_drive(0, 10'd0, 11'd0, 0, 16'hBEEF); step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'h3333); step();
        chk("gap.we_b2", 32'(b2.mem_we), 32'd0);
        p2_drive(0, 10'd0, 11'd0, 0, 16'h0);    step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'h4444); step();
        chk("gap.w1_addr", 32'(b2.mem_addr), 32'd1);
        chk("gap.w1_data", b2.mem_wdata, 32'h44443333);
        chk("gap.w1_done", 32'(b2.done), 32'd1);
        chk("gap.w1_ready", 32'(b2.in_ready), 32'd0);
        chk("gap.w1_ww", 32'(b2.words_written), 32'd2);
        p2_drive(0, 10'd0, 11'd0, 1, 16'h5555); step();
        chk("gap.idle_busy", 32'(b2.busy), 32'd0);
        p2_drive(0, 10'd0, 11'd0, 0, 16'h0);    step();
        chk("gap.we_pulses", 32'(we2_cnt), 32'd2);

        // Reset in the middle of word 1 of a PACK=2 burst
        we2_cnt = 0;
        p2_drive(1, 10'd3, 11'd2, 0, 16'h0);    step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'hAAAA); step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'hABAB); step();
        chk("rst.w0_addr", 32'(b2.mem_addr), 32'd3);
        chk("rst.w0_data", b2.mem_wdata, 32'hABABAAAA);
        p2_drive(0, 10'd0, 11'd0, 1, 16'hBBBB); step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'hCCCC);
        #3 rst = 1'b1;
        #1 chk_p2_zero("rst_async");
        step();
        chk_p2_zero("rst_hold");
        rst = 1'b0;
        p2_drive(0, 10'd0, 11'd0, 0, 16'h0);    step();
        chk("rst.no_partial_write", 32'(we2_cnt), 32'd1);
        p2_drive(1, 10'd40, 11'd1, 0, 16'h0);   step();
        chk("rst.restart_ready", 32'(b2.in_ready), 32'd1);
        p2_drive(0, 10'd0, 11'd0, 1, 16'h5555); step();
        p2_drive(0, 10'd0, 11'd0, 1, 16'h6666); step();
        chk("rst.restart_we", 32'(b2.mem_we), 32'd1);
        chk("rst.restart_addr", 32'(b2.mem_addr), 32'd40);
        chk("rst.restart_data", b2.mem_wdata, 32'h66665555);
        chk("rst.restart_done", 32'(b2.done), 32'd1);
        chk("rst.restart_ww", 32'(b2.words_written), 32'd1);
        p2_drive(0, 10'd0, 11'd0, 0, 16'h0);    step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
